gzip_bit_packer: RTL and testbench

Downstream stage of the static length/distance Huffman encoders in the GZIP compressor. It accepts variable-length, already bit-reversed code words of up to 18 bits, such as `{extra bits, Huffman code}` from `slength`, or a distance code plus its extra bits. It concatenates them LSB-first as RFC 1951 requires and emits a byte stream under a valid/ready handshake. On request it flushes the residual bits, zero-padded to a byte boundary, and flags the final byte.

---
 rtl/gzip_pkg.sv | 22 ++
 rtl/gzip_bit_packer.sv | 98 +++++++++
 tb/tb_gzip_bit_packer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gzip_pkg.sv
// Shared GZIP compressor definitions: default widths, packer FSM states and
// the code-word masking helper.
package gzip_pkg;

  localparam int GZ_CODE_W = 18;
  localparam int GZ_ACC_W  = 32;

  typedef enum logic {
    PK_RUN,
    PK_FLUSH
  } pk_state_t;

  // Keep only the low nbits of data; nbits >= GZ_ACC_W keeps everything.
  function automatic logic [GZ_ACC_W-1:0] gz_mask(input logic [GZ_ACC_W-1:0] data,
                                                  input logic [5:0]          nbits);
    logic [GZ_ACC_W-1:0] m;
    if (nbits >= 6'(GZ_ACC_W)) m = '1;
    else                       m = ~({GZ_ACC_W{1'b1}} << nbits);
    return data & m;
  endfunction

endpackage

// File: rtl/gzip_bit_packer.sv
// LSB-first bit packer: concatenates variable-length code words into a byte
// stream with valid/ready handshake, and pads/drains residual bits on flush.
module gzip_bit_packer
  import gzip_pkg::*;
#(
  parameter int CODE_W = GZ_CODE_W,
  parameter int ACC_W  = GZ_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_data_in,
  input  logic [4:0]        code_bits_in,
  input  logic              code_valid_in,
  output logic              code_ready_out,
  input  logic              flush_in,
  output logic [7:0]        byte_data_out,
  output logic              byte_valid_out,
  input  logic              byte_ready_in,
  output logic              byte_last_out,
  output logic              flush_done_out,
  output logic [31:0]       byte_count_out
);

  localparam int FILL_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0]    acc, acc_next, acc_base, masked;
  logic [FILL_W-1:0]   fill, fill_next, fill_base, pop_bits;
  logic [31:0]         byte_count;
  logic                flush_done, flush_done_next;
  pk_state_t           state, state_next;

  logic [4:0]          nbits;
  logic [GZ_ACC_W-1:0] code_wide, masked_wide;
  logic                push, pop;

  // Oversized lengths saturate to the code width before masking.
  assign nbits       = (code_bits_in > 5'(CODE_W)) ? 5'(CODE_W) : code_bits_in;
  assign code_wide   = GZ_ACC_W'(code_data_in);
  assign masked_wide = gz_mask(code_wide, {1'b0, nbits});
  assign masked      = ACC_W'(masked_wide);

  assign code_ready_out = (state == PK_RUN) && (fill <= FILL_W'(ACC_W - CODE_W));
  assign byte_valid_out = (fill >= FILL_W'(8)) || ((state == PK_FLUSH) && (fill != '0));
  assign byte_data_out  = acc[7:0];
  assign byte_last_out  = (state == PK_FLUSH) && byte_valid_out && (fill <= FILL_W'(8));
  assign flush_done_out = flush_done;
  assign byte_count_out = byte_count;

  assign push     = code_valid_in && code_ready_out;
  assign pop      = byte_valid_out && byte_ready_in;
  assign pop_bits = (fill >= FILL_W'(8)) ? FILL_W'(8) : fill;

  // Pop is applied first so a same-cycle push lands right above the surviving bits.
  always_comb begin
    acc_base  = pop ? (acc >> 8) : acc;
    fill_base = pop ? (fill - pop_bits) : fill;
    acc_next  = acc_base;
    fill_next = fill_base;
    if (push) begin
      acc_next  = acc_base | (masked << fill_base);
      fill_next = fill_base + FILL_W'(nbits);
    end
  end

  always_comb begin
    state_next      = state;
    flush_done_next = 1'b0;
    case (state)
      PK_RUN: begin
        if (flush_in) state_next = PK_FLUSH;
      end
      PK_FLUSH: begin
        if (fill_next == '0) begin
          state_next      = PK_RUN;
          flush_done_next = 1'b1;
        end
      end
      default: state_next = PK_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PK_RUN;
      flush_done <= 1'b0;
      acc        <= '0;
      fill       <= '0;
      byte_count <= '0;
    end else begin
      state      <= state_next;
      flush_done <= flush_done_next;
      acc        <= acc_next;
      fill       <= fill_next;
      if (pop) byte_count <= byte_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gzip_bit_packer.sv
// Directed table plus length-code stream checked against a bit-serial model,
// and a reset-during-stalled-flush sequence.
module tb_gzip_bit_packer;

  localparam int CODE_W = 18;
  localparam int ACC_W  = 32;

  localparam int LBASE[29] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 15, 17, 19, 23, 27, 31,
                               35, 43, 51, 59, 67, 83, 99, 115, 131, 163, 195, 227, 258};
  localparam int LEXT[29]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2,
                               3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 0};

  logic              clk = 1'b0;
  logic              rst;
  logic [CODE_W-1:0] code_data;
  logic [4:0]        code_bits;
  logic              code_valid;
  logic              code_ready;
  logic              flush;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;
  logic              flush_done;
  logic [31:0]       byte_count;

  gzip_bit_packer #(.CODE_W(CODE_W), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .code_data_in  (code_data),
    .code_bits_in  (code_bits),
    .code_valid_in (code_valid),
    .code_ready_out(code_ready),
    .flush_in      (flush),
    .byte_data_out (byte_data),
    .byte_valid_out(byte_valid),
    .byte_ready_in (byte_ready),
    .byte_last_out (byte_last),
    .flush_done_out(flush_done),
    .byte_count_out(byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              cv;
    logic [CODE_W-1:0] cd;
    logic [4:0]        cb;
    logic              fl;
    logic              br;
    logic              ev;
    logic [7:0]        ed;
    logic              el;
    logic              er;
    logic              edn;
    logic [31:0]       ecnt;
    logic [5:0]        efill;
  } vec_t;

  function automatic vec_t mk(input logic cv, input logic [CODE_W-1:0] cd, input logic [4:0] cb,
                              input logic fl, input logic br, input logic ev, input logic [7:0] ed,
                              input logic el, input logic er, input logic edn,
                              input logic [31:0] ecnt, input logic [5:0] efill);
    vec_t v;
    v.cv = cv; v.cd = cd; v.cb = cb; v.fl = fl; v.br = br;
    v.ev = ev; v.ed = ed; v.el = el; v.er = er; v.edn = edn; v.ecnt = ecnt; v.efill = efill;
    return v;
  endfunction

  localparam int NV = 34;
  vec_t tbl[NV];

  // Bit-serial reference: one queue entry per pending bit, oldest first.
  bit          q[$];
  logic [31:0] exp_count;

  task automatic len_code(input int len, output logic [CODE_W-1:0] w, output logic [4:0] nb);
    int          i;
    int          code;
    int          hl;
    logic [7:0]  hc;
    logic [7:0]  rev;
    i = 28;
    while (LBASE[i] > len) i--;
    code = 257 + i;
    if (code <= 279) begin hc = 8'(code - 256);        hl = 7; end
    else             begin hc = 8'(code - 280 + 'hC0); hl = 8; end
    rev = '0;
    for (int k = 0; k < hl; k++) rev[k] = hc[hl-1-k];
    w  = CODE_W'(rev) | CODE_W'((len - LBASE[i]) << hl);
    nb = 5'(hl + LEXT[i]);
  endtask

  task automatic pop_check(input bit in_flush);
    logic [7:0] e;
    int         sz;
    e  = '0;
    sz = q.size();
    for (int k = 0; k < 8; k++) if (q.size() > 0) e[k] = q.pop_front();
    check("rnd.byte", 32'(byte_data), 32'(e));
    check("rnd.last", 32'(byte_last), 32'(in_flush && (sz <= 8)));
    exp_count++;
  endtask

  task automatic idle_inputs();
    code_valid = 1'b0;
    code_data  = '0;
    code_bits  = '0;
    flush      = 1'b0;
  endtask

  initial begin
    logic [CODE_W-1:0] w;
    logic [4:0]        nb;
    logic [31:0]       garbage;
    logic              cv, br;
    int                len;
    bit                done_seen;

    tbl[0]  = mk(1, 'h05,    3,  0, 1,  0, 'h05, 0, 1, 0,  0, 3);
    tbl[1]  = mk(1, 'h1F,    5,  0, 1,  1, 'hFD, 0, 1, 0,  0, 8);
    tbl[2]  = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 0,  1, 0);
    tbl[3]  = mk(1, 'h3FFFF, 18, 0, 0,  1, 'hFF, 0, 0, 0,  1, 18);
    tbl[4]  = mk(0, 'h0,     0,  0, 0,  1, 'hFF, 0, 0, 0,  1, 18);
    tbl[5]  = mk(0, 'h0,     0,  0, 1,  1, 'hFF, 0, 1, 0,  2, 10);
    tbl[6]  = mk(0, 'h0,     0,  0, 1,  0, 'h03, 0, 1, 0,  3, 2);
    tbl[7]  = mk(0, 'h0,     0,  1, 1,  1, 'h03, 1, 0, 0,  3, 2);
    tbl[8]  = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 1,  4, 0);
    tbl[9]  = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 0,  4, 0);
    tbl[10] = mk(1, 'h5,     3,  0, 1,  0, 'h05, 0, 1, 0,  4, 3);
    tbl[11] = mk(0, 'h0,     0,  1, 1,  1, 'h05, 1, 0, 0,  4, 3);
    tbl[12] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 1,  5, 0);
    tbl[13] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 0,  5, 0);
    tbl[14] = mk(0, 'h0,     0,  1, 1,  0, 'h00, 0, 0, 0,  5, 0);
    tbl[15] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 1,  5, 0);
    tbl[16] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 0,  5, 0);
    tbl[17] = mk(1, 'hABC,   12, 0, 0,  1, 'hBC, 0, 1, 0,  5, 12);
    tbl[18] = mk(1, 'h3,     2,  0, 1,  0, 'h3A, 0, 1, 0,  6, 6);
    tbl[19] = mk(0, 'h0,     0,  1, 1,  1, 'h3A, 1, 0, 0,  6, 6);
    tbl[20] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 1,  7, 0);
    tbl[21] = mk(1, 'h3FFFF, 0,  0, 1,  0, 'h00, 0, 1, 0,  7, 0);
    tbl[22] = mk(1, 'h3FFF5, 4,  0, 1,  0, 'h05, 0, 1, 0,  7, 4);
    tbl[23] = mk(1, 'h3FFFF, 31, 0, 1,  1, 'hF5, 0, 0, 0,  7, 22);
    tbl[24] = mk(0, 'h0,     0,  0, 1,  1, 'hFF, 0, 1, 0,  8, 14);
    tbl[25] = mk(0, 'h0,     0,  0, 1,  0, 'h3F, 0, 1, 0,  9, 6);
    tbl[26] = mk(0, 'h0,     0,  1, 1,  1, 'h3F, 1, 0, 0,  9, 6);
    tbl[27] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 1, 10, 0);
    tbl[28] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 0, 10, 0);
    tbl[29] = mk(1, 'h1,     1,  0, 0,  0, 'h01, 0, 1, 0, 10, 1);
    tbl[30] = mk(0, 'h0,     0,  1, 0,  1, 'h01, 1, 0, 0, 10, 1);
    tbl[31] = mk(1, 'hFF,    8,  1, 0,  1, 'h01, 1, 0, 0, 10, 1);
    tbl[32] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 1, 11, 0);
    tbl[33] = mk(0, 'h0,     0,  0, 1,  0, 'h00, 0, 1, 0, 11, 0);

    rst = 1'b1;
    idle_inputs();
    byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.ready", 32'(code_ready), 1);
    check("reset.valid", 32'(byte_valid), 0);
    check("reset.data",  32'(byte_data),  0);
    check("reset.last",  32'(byte_last),  0);
    check("reset.done",  32'(flush_done), 0);
    check("reset.count", byte_count,      0);

    for (int i = 0; i < NV; i++) begin
      code_valid = tbl[i].cv;
      code_data  = tbl[i].cd;
      code_bits  = tbl[i].cb;
      flush      = tbl[i].fl;
      byte_ready = tbl[i].br;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.valid", i), 32'(byte_valid), 32'(tbl[i].ev));
      check($sformatf("v%0d.data",  i), 32'(byte_data),  32'(tbl[i].ed));
      check($sformatf("v%0d.last",  i), 32'(byte_last),  32'(tbl[i].el));
      check($sformatf("v%0d.ready", i), 32'(code_ready), 32'(tbl[i].er));
      check($sformatf("v%0d.done",  i), 32'(flush_done), 32'(tbl[i].edn));
      check($sformatf("v%0d.count", i), byte_count,      tbl[i].ecnt);
      check($sformatf("v%0d.fill",  i), 32'(dut.fill),   32'(tbl[i].efill));
    end

    // Length-code stream with random stalls and garbage above the valid bits.
    idle_inputs();
    exp_count = 32'd11;
    for (int c = 0; c < 400; c++) begin
      cv      = ($urandom_range(3) != 0);
      br      = ($urandom_range(1) == 1);
      len     = int'($urandom_range(258, 3));
      len_code(len, w, nb);
      garbage = $urandom;
      code_valid = cv;
      code_data  = w | CODE_W'(garbage << nb);
      code_bits  = nb;
      byte_ready = br;
      if (byte_valid && br) pop_check(1'b0);
      if (cv && code_ready) for (int k = 0; k < int'(nb); k++) q.push_back(w[k]);
      @(posedge clk);
      #1;
    end

    code_valid = 1'b0;
    flush      = 1'b1;
    byte_ready = 1'b1;
    if (byte_valid) pop_check(1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    done_seen = 1'b0;
    for (int t = 0; t < 50 && !done_seen; t++) begin
      if (flush_done) done_seen = 1'b1;
      else begin
        if (byte_valid) pop_check(1'b1);
        @(posedge clk);
        #1;
      end
    end
    check("rnd.flush_done", 32'(flush_done), 1);
    check("rnd.residual",   32'(q.size()),   0);
    check("rnd.count",      byte_count,      exp_count);

    // Reset in the middle of a stalled flush.
    @(posedge clk);
    #1;
    byte_ready = 1'b0;
    code_valid = 1'b1;
    code_data  = 'h3FFFF;
    code_bits  = 5'd18;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(posedge clk);
    #1;
    check("rst.pre_valid", 32'(byte_valid), 1);
    check("rst.pre_ready", 32'(code_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst.ready", 32'(code_ready), 1);
    check("rst.valid", 32'(byte_valid), 0);
    check("rst.data",  32'(byte_data),  0);
    check("rst.last",  32'(byte_last),  0);
    check("rst.done",  32'(flush_done), 0);
    check("rst.count", byte_count,      0);
    check("rst.fill",  32'(dut.fill),   0);
    rst = 1'b0;
    byte_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d.done",  t), 32'(flush_done), 0);
      check($sformatf("post_rst%0d.valid", t), 32'(byte_valid), 0);
      check($sformatf("post_rst%0d.ready", t), 32'(code_ready), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
